// File: rtl/issue_sched_pkg.sv
// Shared types and constants for the issue scheduler: data widths, opcode
// constants, queue entry layout, FSM states and the LSB classification helper.
package issue_sched_pkg;

   localparam int INS_DAT_W = 32;
   localparam int REG_DAT_W = 32;

   localparam logic [6:0] OPC_LOAD  = 7'b0000011;
   localparam logic [6:0] OPC_STORE = 7'b0100011;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_BLOCK = 2'd1,
      ST_FLUSH = 2'd2
   } sched_state_t;

   typedef struct packed {
      logic [INS_DAT_W-1:0] ins;
      logic                 bj;
      logic [REG_DAT_W-1:0] pc;
      logic [REG_DAT_W-1:0] pjt;
   } iq_entry_t;

   // Loads and stores go to the load/store buffer, everything else to the RS.
   function automatic logic is_lsb_op(input logic [INS_DAT_W-1:0] ins);
      return (ins[6:0] == OPC_LOAD) || (ins[6:0] == OPC_STORE);
   endfunction

endpackage

// File: rtl/issue_sched_if.sv
// Fetch / downstream / dispatch signal bundle of the issue scheduler.
// master = environment side, slave = scheduler side.
interface issue_sched_if;
   import issue_sched_pkg::*;

   logic                 en;
   logic                 iIF_En;
   logic [INS_DAT_W-1:0] iIF_Ins;
   logic                 iIF_Bj;
   logic [REG_DAT_W-1:0] iIF_Pc;
   logic [REG_DAT_W-1:0] iIF_Pjt;
   logic                 oIF_Stall;
   logic                 iROB_Full;
   logic                 iRS_Full;
   logic                 iLSB_Full;
   logic                 iFlush;
   logic                 oIS_En;
   logic [INS_DAT_W-1:0] oIS_Ins;
   logic                 oIS_Bj;
   logic [REG_DAT_W-1:0] oIS_Pc;
   logic [REG_DAT_W-1:0] oIS_Pjt;
   logic [31:0]          oStat_Blk;

   modport master (
      output en, iIF_En, iIF_Ins, iIF_Bj, iIF_Pc, iIF_Pjt,
             iROB_Full, iRS_Full, iLSB_Full, iFlush,
      input  oIF_Stall, oIS_En, oIS_Ins, oIS_Bj, oIS_Pc, oIS_Pjt, oStat_Blk
   );

   modport slave (
      input  en, iIF_En, iIF_Ins, iIF_Bj, iIF_Pc, iIF_Pjt,
             iROB_Full, iRS_Full, iLSB_Full, iFlush,
      output oIF_Stall, oIS_En, oIS_Ins, oIS_Bj, oIS_Pc, oIS_Pjt, oStat_Blk
   );

endinterface

// File: rtl/issue_sched_iq_fifo.sv
// Instruction queue storage: circular buffer with wrapping head/tail pointers
// and an occupancy count; clear has priority over push/pop, i_en low holds all.
module iq_fifo
   import issue_sched_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_en,
   input  logic             i_clr,
   input  logic             i_push,
   input  iq_entry_t        i_data,
   input  logic             i_pop,
   output iq_entry_t        o_head,
   output logic [CNT_W-1:0] o_count
);

   iq_entry_t        r_mem [DEPTH];
   logic [PTR_W-1:0] r_head;
   logic [PTR_W-1:0] r_tail;
   logic [CNT_W-1:0] r_count;

   // Entry storage carries no reset; validity is tracked by the count.
   always_ff @(posedge clk) begin
      if (!rst && i_en && !i_clr && i_push) begin
         r_mem[r_tail] <= i_data;
      end
   end

   // Pointers and count; power-of-two depth lets the pointers wrap naturally.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_head  <= PTR_W'(0);
         r_tail  <= PTR_W'(0);
         r_count <= CNT_W'(0);
      end else if (i_en) begin
         if (i_clr) begin
            r_head  <= PTR_W'(0);
            r_tail  <= PTR_W'(0);
            r_count <= CNT_W'(0);
         end else begin
            if (i_push) begin
               r_tail <= r_tail + PTR_W'(1);
            end
            if (i_pop) begin
               r_head <= r_head + PTR_W'(1);
            end
            case ({i_push, i_pop})
               2'b10:   r_count <= r_count + CNT_W'(1);
               2'b01:   r_count <= r_count - CNT_W'(1);
               default: r_count <= r_count;
            endcase
         end
      end
   end

   assign o_head  = r_mem[r_head];
   assign o_count = r_count;

endmodule

// File: rtl/issue_sched.sv
// Issue scheduler: queues fetched instructions, classifies the head (LSB/RS)
// and dispatches one per cycle. Optional blocked-cycle counter: ISSUE_SCHED_STAT_EN.
module issue_sched
   import issue_sched_pkg::*;
#(
   parameter int IQ_DEPTH     = 4,
   parameter int STALL_MARGIN = 1
) (
   input  logic          clk,
   input  logic          rst,
   issue_sched_if.slave  bus
);

   localparam int CNT_W = $clog2(IQ_DEPTH + 1);

   sched_state_t     r_state;
   sched_state_t     w_state_nxt;
   iq_entry_t        w_head;
   iq_entry_t        w_fetch;
   logic [CNT_W-1:0] w_count;
   logic             w_active;
   logic             w_unit_full;
   logic             w_dispatch;
   logic             w_enqueue;
   logic             w_flush;

   logic                 r_is_en;
   logic [INS_DAT_W-1:0] r_is_ins;
   logic                 r_is_bj;
   logic [REG_DAT_W-1:0] r_is_pc;
   logic [REG_DAT_W-1:0] r_is_pjt;

   assign w_fetch = '{ins: bus.iIF_Ins, bj: bus.iIF_Bj, pc: bus.iIF_Pc, pjt: bus.iIF_Pjt};
   assign w_flush = bus.en & bus.iFlush;

   iq_fifo #(.DEPTH(IQ_DEPTH)) u_iq_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_en    (bus.en),
      .i_clr   (w_flush),
      .i_push  (w_enqueue),
      .i_data  (w_fetch),
      .i_pop   (w_dispatch),
      .o_head  (w_head),
      .o_count (w_count)
   );

   // Dispatch/enqueue decisions; the FLUSH cycle accepts nothing.
   always_comb begin
      w_active    = (r_state != ST_FLUSH);
      w_unit_full = is_lsb_op(w_head.ins) ? bus.iLSB_Full : bus.iRS_Full;
      w_dispatch  = bus.en & w_active & (w_count != CNT_W'(0)) & ~bus.iFlush
                    & ~bus.iROB_Full & ~w_unit_full;
      w_enqueue   = bus.en & bus.iIF_En & ~bus.iFlush & w_active
                    & ((w_count < CNT_W'(IQ_DEPTH)) | w_dispatch);
   end

   // Next-state logic; BLOCK means a valid head is being held back.
   always_comb begin
      w_state_nxt = r_state;
      if (bus.iFlush) begin
         w_state_nxt = ST_FLUSH;
      end else begin
         case (r_state)
            ST_RUN: begin
               if ((w_count != CNT_W'(0)) && !w_dispatch) begin
                  w_state_nxt = ST_BLOCK;
               end else begin
                  w_state_nxt = ST_RUN;
               end
            end
            ST_BLOCK: begin
               if (w_dispatch || (w_count == CNT_W'(0))) begin
                  w_state_nxt = ST_RUN;
               end else begin
                  w_state_nxt = ST_BLOCK;
               end
            end
            ST_FLUSH: w_state_nxt = ST_RUN;
            default:  w_state_nxt = ST_RUN;
         endcase
      end
   end

   // State register, frozen while en is low.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_RUN;
      end else if (bus.en) begin
         r_state <= w_state_nxt;
      end
   end

   // Dispatch register: carries the head only in its pulse cycle, zero otherwise.
   always_ff @(posedge clk) begin
      if (rst || !w_dispatch) begin
         r_is_en  <= 1'b0;
         r_is_ins <= INS_DAT_W'(0);
         r_is_bj  <= 1'b0;
         r_is_pc  <= REG_DAT_W'(0);
         r_is_pjt <= REG_DAT_W'(0);
      end else begin
         r_is_en  <= 1'b1;
         r_is_ins <= w_head.ins;
         r_is_bj  <= w_head.bj;
         r_is_pc  <= w_head.pc;
         r_is_pjt <= w_head.pjt;
      end
   end

   assign bus.oIS_En    = r_is_en;
   assign bus.oIS_Ins   = r_is_ins;
   assign bus.oIS_Bj    = r_is_bj;
   assign bus.oIS_Pc    = r_is_pc;
   assign bus.oIS_Pjt   = r_is_pjt;
   assign bus.oIF_Stall = ((IQ_DEPTH - int'(w_count)) <= STALL_MARGIN);

`ifdef ISSUE_SCHED_STAT_EN
   logic [31:0] r_stat_blk;

   // Saturating count of enabled cycles spent in BLOCK.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_stat_blk <= 32'd0;
      end else if (bus.en && (r_state == ST_BLOCK) && (r_stat_blk != 32'hFFFF_FFFF)) begin
         r_stat_blk <= r_stat_blk + 32'd1;
      end
   end

   assign bus.oStat_Blk = r_stat_blk;
`else
   assign bus.oStat_Blk = 32'd0;
`endif

endmodule
